// File: rtl/fa_serial_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder controller.
// The requester drives start and the operands; the adder returns status and result.
interface fa_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (output start, x, y, ci, input busy, done, s, co);
  modport slave  (input start, x, y, ci, output busy, done, s, co);
endinterface

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder: a single 1-bit full adder is stepped over WIDTH bits, LSB first,
// with the carry held in a flip-flop between bits.
module fa (
  output logic co,
  output logic s,
  input  logic ci,
  input  logic x,
  input  logic y
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module fa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fa_serial_ctrl_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             load, step, finish;
  logic [WIDTH-1:0] xr, yr, sr, sum_r;
  logic             cf, co_r, done_r;
  logic [CNT_W-1:0] cnt;
  logic             fa_co, fa_s;
  logic [WIDTH:0]   sr_ext;
  logic [WIDTH-1:0] sr_nxt;

  fa u_fa (
    .co (fa_co),
    .s  (fa_s),
    .ci (cf),
    .x  (xr[0]),
    .y  (yr[0])
  );

  // New sum bit enters at the MSB; after WIDTH steps the LSB sits at bit 0.
  assign sr_ext = {fa_s, sr};
  assign sr_nxt = sr_ext[WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr     <= '0;
      yr     <= '0;
      sr     <= '0;
      cf     <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      co_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish;
      if (load) begin
        xr  <= bus.x;
        yr  <= bus.y;
        cf  <= bus.ci;
        cnt <= '0;
      end else if (step) begin
        xr  <= xr >> 1;
        yr  <= yr >> 1;
        cf  <= fa_co;
        sr  <= sr_nxt;
        cnt <= cnt + 1'b1;
        if (finish) begin
          sum_r <= sr_nxt;
          co_r  <= fa_co;
        end
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.s    = sum_r;
  assign bus.co   = co_r;
endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for the bit-serial adder at WIDTH=8 and WIDTH=1, driven with
// directed cases plus random start/operand traffic against an arithmetic reference.
module tb_fa_serial_ctrl;
  localparam int W8 = 8;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fa_serial_ctrl_if #(.WIDTH(W8)) if8 ();
  fa_serial_ctrl_if #(.WIDTH(W1)) if1 ();

  fa_serial_ctrl #(.WIDTH(W8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  fa_serial_ctrl #(.WIDTH(W1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  // Reference: an accepted start occupies the adder for WIDTH+1 cycles, the result
  // {co,s} = x + y + ci appearing with done in the last of them.
  int       m8_cnt = 0;
  int       m1_cnt = 0;
  int       q8[$];
  int       q1[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_cnt = 0;
      m1_cnt = 0;
    end else begin
      if (m8_cnt == 0) begin
        if (if8.start) begin
          m8_cnt = W8 + 1;
          q8.push_back((int'(if8.x) + int'(if8.y) + int'(if8.ci)) & 32'h1FF);
        end
      end else m8_cnt--;
      if (m1_cnt == 0) begin
        if (if1.start) begin
          m1_cnt = W1 + 1;
          q1.push_back((int'(if1.x) + int'(if1.y) + int'(if1.ci)) & 32'h3);
        end
      end else m1_cnt--;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  int rd8 = 0, rd1 = 0;
  int last8 = 0, last1 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd8   = q8.size();
      rd1   = q1.size();
      last8 = 0;
      last1 = 0;
    end
    chk("busy8", int'(if8.busy), int'(m8_cnt != 0));
    chk("done8", int'(if8.done), int'(m8_cnt == 1));
    if (if8.done) begin
      if (rd8 < q8.size()) begin
        last8 = q8[rd8];
        rd8++;
      end else chk("unexpected_done8", 1, 0);
    end
    chk("result8", int'({if8.co, if8.s}), last8);
    if (m8_cnt == 0) chk("drain8", rd8, q8.size());

    chk("busy1", int'(if1.busy), int'(m1_cnt != 0));
    chk("done1", int'(if1.done), int'(m1_cnt == 1));
    if (if1.done) begin
      if (rd1 < q1.size()) begin
        last1 = q1[rd1];
        rd1++;
      end else chk("unexpected_done1", 1, 0);
    end
    chk("result1", int'({if1.co, if1.s}), last1);
    if (m1_cnt == 0) chk("drain1", rd1, q1.size());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    if8.start = 1'b1; if8.x = a; if8.y = b; if8.ci = c;
    tick(1);
    if8.start = 1'b0;
    tick(W8 + 1);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    if1.start = 1'b1; if1.x = a; if1.y = b; if1.ci = c;
    tick(1);
    if1.start = 1'b0;
    tick(W1 + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    if8.start = 1'b0; if8.x = '0; if8.y = '0; if8.ci = 1'b0;
    if1.start = 1'b0; if1.x = '0; if1.y = '0; if1.ci = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    tick(5);
    op8(8'hFF, 8'hFF, 1'b1);
    tick(5);

    // Start and changing operands while busy must not disturb the running add.
    if8.start = 1'b1; if8.x = 8'h10; if8.y = 8'h20; if8.ci = 1'b0;
    tick(2);
    if8.x = 8'hAA; if8.y = 8'h55; if8.ci = 1'b1;
    tick(3);
    if8.start = 1'b0;
    tick(W8);

    if8.start = 1'b1; if8.x = 8'h01; if8.y = 8'h01; if8.ci = 1'b0;
    tick(35);
    if8.start = 1'b0;
    tick(W8 + 2);

    // Reset in the middle of an addition discards it.
    if8.start = 1'b1; if8.x = 8'hF0; if8.y = 8'h0F; if8.ci = 1'b1;
    tick(1);
    if8.start = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    op8(8'h03, 8'h04, 1'b0);

    for (int i = 0; i < 8; i++) op1(i[0], i[1], i[2]);

    for (int i = 0; i < 400; i++) begin
      if8.start = ($urandom_range(0, 2) == 0);
      if8.x     = 8'($urandom);
      if8.y     = 8'($urandom);
      if8.ci    = 1'($urandom);
      if1.start = ($urandom_range(0, 1) == 0);
      if1.x     = 1'($urandom);
      if1.y     = 1'($urandom);
      if1.ci    = 1'($urandom);
      tick(1);
    end
    if8.start = 1'b0;
    if1.start = 1'b0;
    tick(W8 + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fa_serial_ctrl.md
Name: fa_serial_ctrl

Overview:
Bit-serial adder controller that sequences a single instance of the team's 1-bit full adder `fa` (ports co, s, ci, x, y) over WIDTH bits. Two WIDTH-bit operands plus a carry-in are loaded on a start handshake. One bit is added per clock, LSB first, with the carry held in a flip-flop between bits. A registered sum, a carry-out and a one-cycle done pulse are produced. It is the area-minimal adder datapath for the coursework designs, trading WIDTH+1 cycles of latency for a single fa cell.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range >= 1.

Ports:
clk    input   1      system clock, rising-edge active
rst_n  input   1      asynchronous active-low reset
start  input   1      request to begin an addition; honoured only in IDLE
x      input   WIDTH  operand A, sampled on the edge that accepts start
y      input   WIDTH  operand B, sampled on the edge that accepts start
ci     input   1      carry-in, sampled on the edge that accepts start
busy   output  1      high while in RUN or DONE
done   output  1      one-cycle pulse: s/co valid
s      output  WIDTH  registered sum
co     output  1      registered carry-out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, s=0, co=0. Operand shift registers, carry flip-flop and bit counter are all cleared to 0. Release is synchronous to the next clk edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - On the edge where start=1: load xr<=x, yr<=y, cf<=ci, cnt<=0, state<=RUN.
  - start=0: remain in IDLE; s/co keep their last values.
- RUN, each edge:
  - fa inputs are x=xr[0], y=yr[0], ci=cf.
  - cf<=fa.co.
  - xr and yr shift right by 1 (MSB filled with 0).
  - The sum bit shifts into the MSB of the internal sum register sr (sr shifts right).
  - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: state<=DONE, s<=final sr, co<=fa.co, done<=1.
- DONE: exactly one cycle. done<=0 and state<=IDLE on the next edge.
- Latency: start accepted at edge E0; done is high in the cycle following edge E_WIDTH. A new start can be accepted at edge E_WIDTH+2 at the earliest.
- busy is combinational from state: 1 in RUN and DONE, 0 in IDLE.
- start while busy=1, including in DONE, is ignored. It is not queued, and operands are not resampled.
- x, y and ci may change freely after acceptance without affecting the result.
- s and co change only on the edge that raises done, or on reset. They hold between operations.
- Arithmetic: {co,s} = x + y + ci, modulo 2^(WIDTH+1), with no overflow flag.
- cnt width is max(1, clog2(WIDTH)). For WIDTH=1, RUN lasts exactly one edge.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values; the partial result is discarded and done is not asserted.
- Exactly one fa instance is used. No '+' operator appears on the datapath.

Test Plan:
- WIDTH=8; x=0x5A, y=0x3C, ci=0, start pulsed 1 cycle -> busy high from E1. done high only in the cycle after E8. s=0x96, co=0.
- WIDTH=8; x=0xFF, y=0x01, ci=0 -> s=0x00, co=1. Then x=0xFF, y=0xFF, ci=1 -> s=0xFF, co=1. Both results must also be held for 5 idle cycles.
- WIDTH=8; start x=0x10, y=0x20, ci=0; during RUN, assert start with x=0xAA, y=0x55 and change the inputs -> result s=0x30, co=0, exactly one done pulse. The second start has no effect.
- WIDTH=8; start held high continuously with x=0x01, y=0x01, ci=0 -> done pulses every WIDTH+2=10 cycles, s=0x02 each time.
- WIDTH=8; start x=0xF0, y=0x0F, ci=1; drop rst_n at E4 -> s=0, co=0, busy=0, done=0 immediately and no done pulse. After release, x=0x03, y=0x04, ci=0 -> s=0x07, co=0.
- WIDTH=1; all 8 combinations of x, y, ci -> {co,s} matches the full-adder truth table, with done in the cycle after E1.
